// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared coordinate type and default game geometry
package game_pkg;

  localparam int COORD_W = 16;

  typedef logic signed [COORD_W-1:0] coord_t;
  // One extra bit so sums and differences of two coordinates never wrap.
  typedef logic signed [COORD_W:0]   wide_t;

  localparam int DEF_PIPE_W = 52;
  localparam int DEF_GAP_H  = 160;
  localparam int DEF_BIRD_W = 34;
  localparam int DEF_BIRD_H = 24;

  // Sign-extend a coordinate into the 17-bit comparison domain.
  function automatic wide_t widen(input logic [COORD_W-1:0] v);
    return wide_t'({v[COORD_W-1], v});
  endfunction

endpackage

// File: rtl/pipe_hit_check.sv
// rtl/pipe_hit_check.sv - overlap test between one pipe slot and the bird box
module pipe_hit_check
  import game_pkg::*;
#(
  parameter int PIPE_W = DEF_PIPE_W,
  parameter int GAP_H  = DEF_GAP_H,
  parameter int BIRD_W = DEF_BIRD_W,
  parameter int BIRD_H = DEF_BIRD_H
) (
  input  logic               valid,
  input  logic [COORD_W-1:0] s,
  input  logic [COORD_W-1:0] g,
  input  logic [COORD_W-1:0] bird_s,
  input  logic [COORD_W-1:0] bird_g,
  output logic               hit
);

  localparam wide_t PW = wide_t'(PIPE_W);
  localparam wide_t GH = wide_t'(GAP_H);
  localparam wide_t BW = wide_t'(BIRD_W);
  localparam wide_t BH = wide_t'(BIRD_H);

  wide_t ps, pg, bs, bg;
  logic  scroll_ov, gap_ov;

  assign ps = widen(s);
  assign pg = widen(g);
  assign bs = widen(bird_s);
  assign bg = widen(bird_g);

  // Bird overlaps the pipe column horizontally.
  assign scroll_ov = (bs + BW > ps) && (bs < ps + PW);
  // Bird sticks out of the gap above or below.
  assign gap_ov    = (bg < pg) || (bg + BH > pg + GH);
  assign hit       = valid && scroll_ov && gap_ov;

endmodule

// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - pipe obstacle slots: spawn, scroll, retire, hit, score (PIPE_FIELD_SCORE_EN enables scoring)
module pipe_field
  import game_pkg::*;
#(
  parameter int NUM_PIPES    = 3,
  parameter int SPEED        = 5,
  parameter int SPAWN_PERIOD = 64,
  parameter int SPAWN_S      = 640,
  parameter int GAP_BASE     = 100,
  parameter int GAP_H        = DEF_GAP_H,
  parameter int PIPE_W       = DEF_PIPE_W,
  parameter int BIRD_W       = DEF_BIRD_W,
  parameter int BIRD_H       = DEF_BIRD_H
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   new_frame,
  input  logic                   run,
  input  logic                   clear,
  input  logic [7:0]             rand_in,
  input  logic [15:0]            bird_s,
  input  logic [15:0]            bird_g,
  output logic [16*NUM_PIPES-1:0] pipe_s,
  output logic [16*NUM_PIPES-1:0] pipe_g,
  output logic [NUM_PIPES-1:0]   pipe_valid,
  output logic                   hit,
  output logic                   overflow,
  output logic [15:0]            score,
  output logic                   score_pulse
);

  localparam int              CNT_W    = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_PERIOD - 1);
  localparam wide_t           STEP     = wide_t'(SPEED);
  localparam wide_t           PW       = wide_t'(PIPE_W);

  coord_t               s_q [NUM_PIPES];
  coord_t               g_q [NUM_PIPES];
  coord_t               s_d [NUM_PIPES];
  coord_t               g_d [NUM_PIPES];
  wide_t                s_nx [NUM_PIPES];
  logic [NUM_PIPES-1:0] valid_q, valid_d, hit_vec;
  logic [CNT_W-1:0]     cnt_q;
  logic                 hit_q, ovf_q, ovf_d, placed, upd;

  assign upd = new_frame & run;

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_slot
    assign s_nx[i] = widen(s_q[i]) - STEP;

    pipe_hit_check #(
      .PIPE_W(PIPE_W), .GAP_H(GAP_H), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H)
    ) u_hit (
      .valid (valid_q[i]),
      .s     (s_q[i]),
      .g     (g_q[i]),
      .bird_s(bird_s),
      .bird_g(bird_g),
      .hit   (hit_vec[i])
    );

    assign pipe_s[16*i +: 16] = s_q[i];
    assign pipe_g[16*i +: 16] = g_q[i];
  end

  // Scroll and retire live slots, then drop a due pipe into the lowest free slot.
  always_comb begin
    s_d     = s_q;
    g_d     = g_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    placed  = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (valid_q[i]) begin
        if (s_nx[i] < -PW) valid_d[i] = 1'b0;
        else               s_d[i]     = s_nx[i][COORD_W-1:0];
      end
    end
    if (cnt_q == '0) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        if (!placed && !valid_d[i]) begin
          valid_d[i] = 1'b1;
          s_d[i]     = coord_t'(SPAWN_S);
          g_d[i]     = coord_t'(GAP_BASE) + coord_t'({8'h00, rand_in});
          placed     = 1'b1;
        end
      end
      if (!placed) ovf_d = 1'b1;
    end
  end

  // Slot registers, spawn counter, sticky hit and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        s_q[i] <= '0;
        g_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        s_q[i] <= '0;
        g_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (run) hit_q <= hit_q | (|hit_vec);
      if (upd) begin
        s_q     <= s_d;
        g_q     <= g_d;
        valid_q <= valid_d;
        ovf_q   <= ovf_d;
        cnt_q   <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign pipe_valid = valid_q;
  assign hit        = hit_q;
  assign overflow   = ovf_q;

`ifdef PIPE_FIELD_SCORE_EN
  logic [NUM_PIPES-1:0] pass_vec;
  logic [3:0]           pass_cnt;
  logic [16:0]          score_sum;
  logic [15:0]          score_q;
  logic                 pulse_q;

  // A pipe passes when its trailing edge crosses the bird's leading coordinate.
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pass
    assign pass_vec[i] = valid_q[i]
                      && (widen(s_q[i]) + PW >= widen(bird_s))
                      && (s_nx[i] + PW < widen(bird_s));
  end

  // Number of pipes passed in this frame.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < NUM_PIPES; i++) pass_cnt = pass_cnt + {3'b000, pass_vec[i]};
  end

  assign score_sum = {1'b0, score_q} + {13'b0, pass_cnt};

  // Saturating score with a one-cycle pulse whenever it moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_q <= '0;
      pulse_q <= 1'b0;
    end else if (clear) begin
      score_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (upd) begin
        score_q <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
        pulse_q <= (pass_cnt != 4'd0) && (score_q != 16'hFFFF);
      end
    end
  end

  assign score       = score_q;
  assign score_pulse = pulse_q;
`else
  assign score       = '0;
  assign score_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - randomized and directed self-checking bench for pipe_field
module tb_pipe_field;

  localparam int NP = 3;
`ifdef PIPE_FIELD_SCORE_EN
  localparam bit SC_EN = 1'b1;
`else
  localparam bit SC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, new_frame, run, clear;
  logic [7:0]  rand_in;
  logic [15:0] bird_s, bird_g;
  logic [47:0] ps_a, pg_a, ps_b, pg_b;
  logic [2:0]  pv_a, pv_b;
  logic        hit_a, hit_b, ovf_a, ovf_b, sp_a, sp_b;
  logic [15:0] sc_a, sc_b;

  always #5 clk = ~clk;

  pipe_field u_dut (
    .clk(clk), .rst(rst), .new_frame(new_frame), .run(run), .clear(clear),
    .rand_in(rand_in), .bird_s(bird_s), .bird_g(bird_g),
    .pipe_s(ps_a), .pipe_g(pg_a), .pipe_valid(pv_a), .hit(hit_a),
    .overflow(ovf_a), .score(sc_a), .score_pulse(sp_a)
  );

  pipe_field #(.SPAWN_PERIOD(16)) u_fast (
    .clk(clk), .rst(rst), .new_frame(new_frame), .run(run), .clear(clear),
    .rand_in(rand_in), .bird_s(bird_s), .bird_g(bird_g),
    .pipe_s(ps_b), .pipe_g(pg_b), .pipe_valid(pv_b), .hit(hit_b),
    .overflow(ovf_b), .score(sc_b), .score_pulse(sp_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: index 0 = default build, index 1 = SPAWN_PERIOD 16.
  int period [2];
  int m_s    [2][NP];
  int m_g    [2][NP];
  bit m_v    [2][NP];
  int m_frm  [2];
  int m_score[2];
  bit m_pulse[2];
  bit m_hit  [2];
  bit m_ovf  [2];
  int cur_bs, cur_bg;
  bit seen_pulse_a, seen_hit_a;

  task automatic model_clear(input int k);
    for (int j = 0; j < NP; j++) begin
      m_s[k][j] = 0; m_g[k][j] = 0; m_v[k][j] = 1'b0;
    end
    m_frm[k] = 0; m_score[k] = 0; m_pulse[k] = 1'b0; m_hit[k] = 1'b0; m_ovf[k] = 1'b0;
  endtask

  function automatic bit any_overlap(input int k);
    for (int j = 0; j < NP; j++)
      if (m_v[k][j] && (cur_bs + 34 > m_s[k][j]) && (cur_bs < m_s[k][j] + 52) &&
          ((cur_bg < m_g[k][j]) || (cur_bg + 24 > m_g[k][j] + 160)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_update(input int k, input int rin);
    int passed = 0;
    int slot   = -1;
    for (int j = 0; j < NP; j++) begin
      if (m_v[k][j]) begin
        int sn = m_s[k][j] - 5;
        if ((m_s[k][j] + 52 >= cur_bs) && (sn + 52 < cur_bs)) passed++;
        if (sn < -52) m_v[k][j] = 1'b0;
        else          m_s[k][j] = sn;
      end
    end
    if (m_frm[k] % period[k] == 0) begin
      for (int j = 0; j < NP; j++) if (slot < 0 && !m_v[k][j]) slot = j;
      if (slot >= 0) begin
        m_v[k][slot] = 1'b1; m_s[k][slot] = 640; m_g[k][slot] = 100 + rin;
      end else begin
        m_ovf[k] = 1'b1;
      end
    end
    m_frm[k]++;
    m_pulse[k] = (passed > 0) && (m_score[k] < 65535);
    m_score[k] = (m_score[k] + passed > 65535) ? 65535 : m_score[k] + passed;
  endtask

  function automatic logic signed [15:0] slot_s(input int k, input int j);
    if (k == 0) return ps_a[16*j +: 16];
    return ps_b[16*j +: 16];
  endfunction

  function automatic logic signed [15:0] slot_g(input int k, input int j);
    if (k == 0) return pg_a[16*j +: 16];
    return pg_b[16*j +: 16];
  endfunction

  task automatic check_state(input string ph);
    for (int k = 0; k < 2; k++) begin
      logic [2:0] ev;
      for (int j = 0; j < NP; j++) ev[j] = m_v[k][j];
      check($sformatf("%s_valid%0d", ph, k), (k == 0) ? pv_a : pv_b, ev);
      for (int j = 0; j < NP; j++) begin
        if (m_v[k][j]) begin
          check($sformatf("%s_s%0d_%0d", ph, k, j), slot_s(k, j), m_s[k][j]);
          check($sformatf("%s_g%0d_%0d", ph, k, j), slot_g(k, j), m_g[k][j]);
        end
      end
      check($sformatf("%s_score%0d", ph, k), (k == 0) ? sc_a : sc_b, SC_EN ? m_score[k] : 0);
      check($sformatf("%s_pulse%0d", ph, k), (k == 0) ? sp_a : sp_b, SC_EN ? m_pulse[k] : 1'b0);
      check($sformatf("%s_ovf%0d", ph, k), (k == 0) ? ovf_a : ovf_b, m_ovf[k]);
      check($sformatf("%s_hit%0d", ph, k), (k == 0) ? hit_a : hit_b, m_hit[k]);
    end
  endtask

  // One frame: drive inputs, check after the update edge and again one cycle later.
  task automatic do_frame(input bit nf, input bit r, input bit c, input int rin,
                          input int bs, input int bg, input int idle);
    @(negedge clk);
    new_frame = nf; run = r; clear = c; rand_in = 8'(rin);
    bird_s = 16'(bs); bird_g = 16'(bg);
    cur_bs = bs; cur_bg = bg;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (c) model_clear(k);
      else begin
        if (r && any_overlap(k)) m_hit[k] = 1'b1;
        if (nf && r) model_update(k, rin & 255);
        else         m_pulse[k] = 1'b0;
      end
    end
    @(negedge clk);
    new_frame = 1'b0; clear = 1'b0;
    seen_pulse_a = sp_a;
    seen_hit_a   = hit_a;
    check_state("e0");
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r && any_overlap(k)) m_hit[k] = 1'b1;
      m_pulse[k] = 1'b0;
    end
    @(negedge clk);
    check_state("e1");
    repeat (idle) @(posedge clk);
  endtask

  initial begin
    int bs, bg;
    period[0] = 64; period[1] = 16;
    model_clear(0); model_clear(1);
    rst = 1'b1; new_frame = 1'b0; run = 1'b0; clear = 1'b0;
    rand_in = '0; bird_s = '0; bird_g = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", pv_a, 3'b000);
    check("rst_score", sc_a, 0);
    check("rst_hit", hit_a, 0);
    check_state("rst");

    // clear together with a frame pulse: clear wins
    do_frame(1'b1, 1'b1, 1'b1, 0, 200, 150, 0);
    check("clr_valid", pv_a, 3'b000);
    check("clr_ovf", ovf_a, 0);

    // spawn, scroll, pass and retire with a bird inside the gap
    for (int f = 0; f < 193; f++) begin
      do_frame(1'b1, 1'b1, 1'b0, 0, 200, 150, 0);
      if (f == 0) begin
        check("a_v_first", pv_a, 3'b001);
        check("a_s_first", $signed(ps_a[15:0]), 640);
        check("a_g_first", pg_a[15:0], 100);
      end
      if (f == 1)   check("a_s_scroll", $signed(ps_a[15:0]), 635);
      if (f == 63)  check("a_v63", pv_a, 3'b001);
      if (f == 64)  check("a_v64", pv_a, 3'b011);
      if (f == 98)  check("a_pulse98", seen_pulse_a, 0);
      if (f == 99) begin
        check("a_pulse99", seen_pulse_a, SC_EN);
        check("a_score99", sc_a, SC_EN ? 1 : 0);
        check("a_s99", $signed(ps_a[15:0]), 145);
      end
      if (f == 138) check("a_v138", pv_a, 3'b111);
      if (f == 139) check("a_v139", pv_a, 3'b110);
      if (f == 47)  check("b_ovf47", ovf_b, 0);
      if (f == 48) begin
        check("b_ovf48", ovf_b, 1);
        check("b_v48", pv_b, 3'b111);
      end
      if (f == 192) begin
        check("a_v192", pv_a, 3'b111);
        check("a_s192", $signed(ps_a[15:0]), 640);
        check("a_hit_none", hit_a, 0);
      end
    end

    // collision below the gap
    for (int rep = 0; rep < 2; rep++) begin
      do_frame(1'b0, 1'b1, 1'b1, 0, 200, 50, 0);
      for (int f = 0; f < 90; f++) begin
        do_frame(1'b1, 1'b1, 1'b0, 0, 200, 50, 0);
        if (f == 81) check("h_hit81", hit_a, 0);
        if (f == 82) begin
          check("h_s82", $signed(ps_a[15:0]), 230);
          check("h_hit82_e0", seen_hit_a, 0);
          check("h_hit82_e1", hit_a, 1);
        end
        if (f == 89) check("h_hit_sticky", hit_a, 1);
      end
      if (rep == 0) begin
        do_frame(1'b0, 1'b1, 1'b1, 0, 200, 50, 0);
        check("h_hit_clear", hit_a, 0);
      end
    end

    // asynchronous reset in the middle of a frame pulse
    @(negedge clk);
    new_frame = 1'b1; run = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", pv_a, 3'b000);
    check("arst_hit", hit_a, 0);
    check("arst_ovf", ovf_b, 0);
    @(negedge clk);
    new_frame = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear(0); model_clear(1);
    do_frame(1'b1, 1'b1, 1'b0, 7, 200, 150, 0);
    check("arst_first", pv_a, 3'b001);
    check("arst_g", pg_a[15:0], 107);

    // randomized play
    bs = 200; bg = 150;
    for (int f = 0; f < 1500; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        bs = int'($urandom_range(0, 760)) - 60;
        bg = int'($urandom_range(0, 300));
      end
      do_frame($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 199) == 0, int'($urandom_range(0, 255)),
               bs, bg, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
